// File: rtl/vga_timing_pkg.sv
// Shared raster presets and helpers for the VGA timing generator.
package vga_timing_pkg;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // 640x480@60 (25.175 MHz pixel clock), negative syncs
    localparam int VGA640_H_ACTIVE = 640;
    localparam int VGA640_H_FP     = 16;
    localparam int VGA640_H_SYNC   = 96;
    localparam int VGA640_H_BP     = 48;
    localparam int VGA640_V_ACTIVE = 480;
    localparam int VGA640_V_FP     = 10;
    localparam int VGA640_V_SYNC   = 2;
    localparam int VGA640_V_BP     = 33;
    localparam bit VGA640_H_POL    = 1'b0;
    localparam bit VGA640_V_POL    = 1'b0;

    // 800x600@60 (40 MHz pixel clock), positive syncs
    localparam int SVGA800_H_ACTIVE = 800;
    localparam int SVGA800_H_FP     = 40;
    localparam int SVGA800_H_SYNC   = 128;
    localparam int SVGA800_H_BP     = 88;
    localparam int SVGA800_V_ACTIVE = 600;
    localparam int SVGA800_V_FP     = 1;
    localparam int SVGA800_V_SYNC   = 4;
    localparam int SVGA800_V_BP     = 23;
    localparam bit SVGA800_H_POL    = 1'b1;
    localparam bit SVGA800_V_POL    = 1'b1;

    // 1280x720@60 (74.25 MHz pixel clock), positive syncs
    localparam int HD720_H_ACTIVE = 1280;
    localparam int HD720_H_FP     = 110;
    localparam int HD720_H_SYNC   = 40;
    localparam int HD720_H_BP     = 220;
    localparam int HD720_V_ACTIVE = 720;
    localparam int HD720_V_FP     = 5;
    localparam int HD720_V_SYNC   = 5;
    localparam int HD720_V_BP     = 20;
    localparam bit HD720_H_POL    = 1'b1;
    localparam bit HD720_V_POL    = 1'b1;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync/active/terminal decode.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter bit POL    = 1'b0,
    localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP),
    localparam int CW    = $clog2(TOTAL)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          en,
    input  logic          carry_in,
    output logic [CW-1:0] count,
    output logic          sync,
    output logic          active,
    output logic          tc
);

    // Extra bit so a sync region ending exactly at TOTAL still compares correctly
    logic [CW:0] count_ext;
    logic        in_sync;

    assign count_ext = {1'b0, count};
    assign in_sync   = (count_ext >= (CW+1)'(ACTIVE + FP)) &&
                       (count_ext <  (CW+1)'(ACTIVE + FP + SYNC));
    assign sync      = in_sync ? POL : ~POL;
    assign active    = count < CW'(ACTIVE);
    assign tc        = count == CW'(TOTAL - 1);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (en && carry_in) begin
            count <= tc ? '0 : count + CW'(1);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered sync/DE/window/strobe outputs.
// Define VGA_FRAME_CNT_EN to add the 16-bit o_frame counter output.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit H_POL       = 1'b0,
    parameter bit V_POL       = 1'b0,
    parameter int SCALE_SHIFT = 0,
    parameter int V_WIN_STA   = 0,
    parameter int V_WIN_END   = 480,
    parameter int X_W         = 10,
    parameter int Y_W         = 9
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_pix_stb,
    output logic           o_hs,
    output logic           o_vs,
    output logic           o_de,
    output logic           o_win,
    output logic [X_W-1:0] o_x,
    output logic [Y_W-1:0] o_y,
    output logic           o_line_end,
    output logic           o_frame_end,
    output logic           o_animate
`ifdef VGA_FRAME_CNT_EN
    ,
    output logic [15:0]    o_frame
`endif
);

    localparam int H_TOTAL = vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int X_MAX   = (H_ACTIVE - 1) >> SCALE_SHIFT;
    localparam int Y_MAX   = (V_WIN_END - V_WIN_STA - 1) >> SCALE_SHIFT;

    logic [HW-1:0]  h_count;
    logic [VW-1:0]  v_count;
    logic           h_sync, v_sync, h_act, v_act, h_tc, v_tc;
    logic [VW:0]    v_rel;
    logic           v_below, v_above, v_last_act;
    logic [HW-1:0]  h_scaled;
    logic [VW-1:0]  v_scaled;
    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
    ) u_h_axis (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .en(i_pix_stb), .carry_in(1'b1),
        .count(h_count), .sync(h_sync), .active(h_act), .tc(h_tc)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
    ) u_v_axis (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .en(i_pix_stb), .carry_in(h_tc),
        .count(v_count), .sync(v_sync), .active(v_act), .tc(v_tc)
    );

    // Borrow out of v - V_WIN_STA flags lines above the window without a constant compare
    assign v_rel      = {1'b0, v_count} - (VW+1)'(V_WIN_STA);
    assign v_below    = v_rel[VW];
    assign v_above    = v_count >= VW'(V_WIN_END);
    assign v_last_act = v_count == VW'(V_ACTIVE - 1);
    assign h_scaled   = h_count >> SCALE_SHIFT;
    assign v_scaled   = v_rel[VW-1:0] >> SCALE_SHIFT;
    assign x_next     = h_act ? X_W'(h_scaled) : X_W'(X_MAX);
    assign y_next     = v_below ? '0 : (v_above ? Y_W'(Y_MAX) : Y_W'(v_scaled));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_hs        <= ~H_POL;
            o_vs        <= ~V_POL;
            o_de        <= 1'b0;
            o_win       <= 1'b0;
            o_x         <= '0;
            o_y         <= '0;
            o_line_end  <= 1'b0;
            o_frame_end <= 1'b0;
            o_animate   <= 1'b0;
        end else begin
            o_line_end  <= i_pix_stb && h_tc;
            o_frame_end <= i_pix_stb && h_tc && v_tc;
            o_animate   <= i_pix_stb && h_tc && v_last_act;
            if (i_pix_stb) begin
                o_hs  <= h_sync;
                o_vs  <= v_sync;
                o_de  <= h_act && v_act;
                o_win <= h_act && v_act && !v_below && !v_above;
                o_x   <= x_next;
                o_y   <= y_next;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_frame <= '0;
        end else if (i_pix_stb && h_tc && v_tc) begin
            o_frame <= o_frame + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a small raster (15x10) so whole frames fit in a short run.
module tb_vga_timing_gen;

    localparam int H_ACTIVE = 8, H_FP = 2, H_SYNC = 3, H_BP = 2;
    localparam int V_ACTIVE = 6, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int H_TOTAL = 15, V_TOTAL = 10;
    localparam bit H_POL = 1'b0, V_POL = 1'b1;
    localparam int SCALE_SHIFT = 1, V_WIN_STA = 1, V_WIN_END = 5;
    localparam int X_W = 4, Y_W = 3;

    typedef struct packed {
        logic           hs, vs, de, win;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic           le, fe, an;
        logic [15:0]    frame;
    } exp_t;

    logic           clk = 1'b0;
    logic           i_rst_n, i_pix_stb;
    logic           o_hs, o_vs, o_de, o_win, o_line_end, o_frame_end, o_animate;
    logic [X_W-1:0] o_x;
    logic [Y_W-1:0] o_y;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]    o_frame;
`endif

    int    compared = 0;
    int    mismatched = 0;
    exp_t  exp_q[$];
    exp_t  last_exp;
    int    mh = 0, mv = 0;
    logic [15:0] mframe = '0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .H_POL(H_POL), .V_POL(V_POL), .SCALE_SHIFT(SCALE_SHIFT),
        .V_WIN_STA(V_WIN_STA), .V_WIN_END(V_WIN_END), .X_W(X_W), .Y_W(Y_W)
    ) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
        .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de), .o_win(o_win),
        .o_x(o_x), .o_y(o_y), .o_line_end(o_line_end),
        .o_frame_end(o_frame_end), .o_animate(o_animate)
`ifdef VGA_FRAME_CNT_EN
        , .o_frame(o_frame)
`endif
    );

    function automatic exp_t reset_exp();
        exp_t e;
        e = '0;
        e.hs = ~H_POL;
        e.vs = ~V_POL;
        return e;
    endfunction

    // Expected outputs for the pixel (h, v) sampled on a strobe, straight from the raster rules
    function automatic exp_t pixel_exp(input int h, input int v);
        exp_t e;
        e = '0;
        e.hs  = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? H_POL : ~H_POL;
        e.vs  = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? V_POL : ~V_POL;
        e.de  = (h < H_ACTIVE) && (v < V_ACTIVE);
        e.win = e.de && (v >= V_WIN_STA) && (v < V_WIN_END);
        e.x   = X_W'((h < H_ACTIVE) ? (h >> SCALE_SHIFT) : ((H_ACTIVE - 1) >> SCALE_SHIFT));
        if (v < V_WIN_STA)
            e.y = '0;
        else if (v >= V_WIN_END)
            e.y = Y_W'((V_WIN_END - V_WIN_STA - 1) >> SCALE_SHIFT);
        else
            e.y = Y_W'((v - V_WIN_STA) >> SCALE_SHIFT);
        e.le = (h == H_TOTAL - 1);
        e.fe = e.le && (v == V_TOTAL - 1);
        e.an = e.le && (v == V_ACTIVE - 1);
        return e;
    endfunction

    task automatic applyStimulus(input logic stb, input logic rst_n_in);
        exp_t e;
        i_pix_stb = stb;
        i_rst_n   = rst_n_in;
        if (!rst_n_in) begin
            e = reset_exp();
            mh = 0;
            mv = 0;
            mframe = '0;
        end else if (stb) begin
            e = pixel_exp(mh, mv);
            if (e.fe) mframe = mframe + 16'd1;
            if (mh == H_TOTAL - 1) begin
                mh = 0;
                mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end else begin
            e = last_exp;
            e.le = 1'b0;
            e.fe = 1'b0;
            e.an = 1'b0;
        end
        e.frame = mframe;
        last_exp = e;
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int expv);
        compared++;
        if (act != expv) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: every edge after a stimulus cycle presents one set of registered outputs
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("o_hs", int'(o_hs), int'(e.hs));
            checkOutput("o_vs", int'(o_vs), int'(e.vs));
            checkOutput("o_de", int'(o_de), int'(e.de));
            checkOutput("o_win", int'(o_win), int'(e.win));
            checkOutput("o_x", int'(o_x), int'(e.x));
            checkOutput("o_y", int'(o_y), int'(e.y));
            checkOutput("o_line_end", int'(o_line_end), int'(e.le));
            checkOutput("o_frame_end", int'(o_frame_end), int'(e.fe));
            checkOutput("o_animate", int'(o_animate), int'(e.an));
`ifdef VGA_FRAME_CNT_EN
            checkOutput("o_frame", int'(o_frame), int'(e.frame));
`endif
        end
    end

    initial begin
        i_rst_n   = 1'b0;
        i_pix_stb = 1'b0;
        last_exp  = reset_exp();
        $display("[TB] start");

        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);

        // Strobe every 4th clock for a bit over one frame: levels must hold between strobes
        for (int i = 0; i < 800; i++) applyStimulus(i % 4 == 0, 1'b1);

        // Continuous strobe, then reset mid-frame with the strobe still high
        for (int i = 0; i < 52; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);

        // Three full frames plus a little of continuous strobe
        for (int i = 0; i < 460; i++) applyStimulus(1'b1, 1'b1);

        // Irregular strobe spacing
        for (int i = 0; i < 200; i++) applyStimulus((i % 3) != 1 && (i % 7) != 5, 1'b1);

        @(negedge clk);
        #1;
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
